// File: rtl/jtframe_snd_mailbox_pkg.sv
// Shared constants for the main-to-sound CPU mailbox.
// FIFO depth, out-of-range read value and counter widths.
package jtframe_snd_mailbox_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int NMI_CW     = 4;
    localparam int QCW        = 3;

    localparam logic [63:0] RD_OOR = '1;

endpackage

// File: rtl/jtframe_snd_mailbox_fifo.sv
// 4-deep command FIFO that replaces latch 0 when
// JTFRAME_SNDMBOX_FIFO_EN is defined; push/pop arrive pre-qualified.
module jtframe_snd_mailbox_fifo
    import jtframe_snd_mailbox_pkg::*;
#(
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          full, do_push, do_pop;

    assign full    = cnt == (PW+1)'(FIFO_DEPTH);
    assign empty   = cnt == '0;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full push needs
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            if (do_push && !do_pop) cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
            if (push && !do_push) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_snd_mailbox.sv
// Main-to-sound CPU mailbox: command latches, reply latch, NMI and queued INT.
// Define JTFRAME_SNDMBOX_FIFO_EN to turn latch 0 into a 4-deep FIFO.
module jtframe_snd_mailbox
    import jtframe_snd_mailbox_pkg::*;
#(
    parameter int LATCHES  = 2,
    parameter int DW       = 8,
    parameter int AW       = 1,
    parameter int NMI_LEN  = 4,
    parameter int INT_QMAX = 3
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               main_wr,
    input  logic [AW-1:0]      main_addr,
    input  logic [DW-1:0]      main_din,
    input  logic               main_rd,
    output logic [DW-1:0]      main_dout,
    output logic               reply_full,
    input  logic               snd_rd,
    input  logic [AW-1:0]      snd_addr,
    output logic [DW-1:0]      snd_dout,
    input  logic               snd_wr,
    input  logic [DW-1:0]      snd_din,
    output logic [LATCHES-1:0] pending,
    input  logic               snd_int,
    input  logic               iack,
    output logic               int_n,
    output logic               nmi_n,
    input  logic               nmi_en,
    output logic               ovf_flag
);

    logic [DW-1:0]      latch [LATCHES];
    logic [LATCHES-1:0] pend;
    logic               wr_ok, rd_ok;

    assign wr_ok = cen & main_wr & (int'(main_addr) < LATCHES);
    assign rd_ok = cen & snd_rd;

    // Write beats read on the same latch so a fresh command is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATCHES; i++) latch[i] <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < LATCHES; i++) begin
                if (wr_ok && main_addr == AW'(i)) begin
                    latch[i] <= main_din;
                    pend[i]  <= 1'b1;
                end else if (rd_ok && snd_addr == AW'(i)) begin
                    pend[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef JTFRAME_SNDMBOX_FIFO_EN
    logic [DW-1:0] fifo_head;
    logic          fifo_empty;

    jtframe_snd_mailbox_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_ok && main_addr == '0),
        .pop   (rd_ok && snd_addr == '0),
        .din   (main_din),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .ovf   (ovf_flag)
    );

    always_comb begin
        pending    = pend;
        pending[0] = ~fifo_empty;
        snd_dout   = RD_OOR[DW-1:0];
        for (int i = 1; i < LATCHES; i++)
            if (snd_addr == AW'(i)) snd_dout = latch[i];
        if (snd_addr == '0)
            snd_dout = fifo_empty ? RD_OOR[DW-1:0] : fifo_head;
    end
`else
    assign ovf_flag = 1'b0;

    always_comb begin
        pending  = pend;
        snd_dout = RD_OOR[DW-1:0];
        for (int i = 0; i < LATCHES; i++)
            if (snd_addr == AW'(i)) snd_dout = latch[i];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dout  <= '0;
            reply_full <= 1'b0;
        end else if (cen) begin
            if (snd_wr) begin
                main_dout  <= snd_din;
                reply_full <= 1'b1;
            end else if (main_rd) begin
                reply_full <= 1'b0;
            end
        end
    end

    logic [NMI_CW-1:0] nmi_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_cnt <= '0;
        end else if (cen) begin
            if (wr_ok && nmi_en) nmi_cnt <= NMI_CW'(NMI_LEN);
            else if (nmi_cnt != '0) nmi_cnt <= nmi_cnt - 1'b1;
        end
    end

    assign nmi_n = nmi_cnt == '0;

    logic           int_last, int_edge, ack;
    logic [QCW-1:0] q, q_nx;

    assign int_edge = snd_int & ~int_last;
    assign ack      = iack & (q != '0);

    // Edge and acknowledge together cancel out
    always_comb begin
        q_nx = q;
        if (int_edge && !ack) begin
            if (q != QCW'(INT_QMAX)) q_nx = q + 1'b1;
        end else if (ack && !int_edge) begin
            q_nx = q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_last <= 1'b0;
            q        <= '0;
            int_n    <= 1'b1;
        end else if (cen) begin
            int_last <= snd_int;
            q        <= q_nx;
            int_n    <= q_nx == '0;
        end
    end

endmodule

// File: tb/tb_jtframe_snd_mailbox.sv
// Scoreboard bench for jtframe_snd_mailbox (3 latches, AW=2).
// Build with JTFRAME_SNDMBOX_FIFO_EN to exercise the latch-0 FIFO.
module tb_jtframe_snd_mailbox;

    localparam int LATCHES = 3;
    localparam int DW      = 8;
    localparam int AW      = 2;

    logic               clk = 0;
    logic               rst_n;
    logic               cen;
    logic               main_wr;
    logic [AW-1:0]      main_addr;
    logic [DW-1:0]      main_din;
    logic               main_rd;
    logic [DW-1:0]      main_dout;
    logic               reply_full;
    logic               snd_rd;
    logic [AW-1:0]      snd_addr;
    logic [DW-1:0]      snd_dout;
    logic               snd_wr;
    logic [DW-1:0]      snd_din;
    logic [LATCHES-1:0] pending;
    logic               snd_int;
    logic               iack;
    logic               int_n;
    logic               nmi_n;
    logic               nmi_en;
    logic               ovf_flag;

    jtframe_snd_mailbox #(
        .LATCHES  (LATCHES),
        .DW       (DW),
        .AW       (AW),
        .NMI_LEN  (4),
        .INT_QMAX (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .main_wr    (main_wr),
        .main_addr  (main_addr),
        .main_din   (main_din),
        .main_rd    (main_rd),
        .main_dout  (main_dout),
        .reply_full (reply_full),
        .snd_rd     (snd_rd),
        .snd_addr   (snd_addr),
        .snd_dout   (snd_dout),
        .snd_wr     (snd_wr),
        .snd_din    (snd_din),
        .pending    (pending),
        .snd_int    (snd_int),
        .iack       (iack),
        .int_n      (int_n),
        .nmi_n      (nmi_n),
        .nmi_en     (nmi_en),
        .ovf_flag   (ovf_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        main_wr = 0;
        main_rd = 0;
        snd_rd  = 0;
        snd_wr  = 0;
        iack    = 0;
        nmi_en  = 0;
    endtask

    task automatic cmd_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic nmi);
        main_wr   = 1;
        main_addr = a;
        main_din  = d;
        nmi_en    = nmi;
        tick();
        idle();
    endtask

    task automatic int_pulse();
        snd_int = 1;
        tick();
        snd_int = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; cen = 1; idle();
        main_addr = 0; main_din = 0; snd_addr = 0; snd_din = 0; snd_int = 0;
        tick(); tick();

        expect_val("rst_pending", 0);   observe(pending);
        expect_val("rst_reply_full", 0); observe(reply_full);
        expect_val("rst_main_dout", 0); observe(main_dout);
        expect_val("rst_int_n", 1);     observe(int_n);
        expect_val("rst_nmi_n", 1);     observe(nmi_n);
        expect_val("rst_ovf", 0);       observe(ovf_flag);
        snd_addr = 1; #1;
        expect_val("rst_latch1", 0);    observe(snd_dout);
        rst_n = 1;
        tick();

        // command write with NMI
        expect_val("t1_pending", 3'b001);
        expect_val("t1_dout", 8'h5A);
        expect_val("t1_nmi_low0", 0);
        cmd_wr(0, 8'h5A, 1);
        snd_addr = 0; #1;
        observe(pending); observe(snd_dout); observe(nmi_n);
        for (int k = 1; k <= 3; k++) begin
            expect_val("t1_nmi_low", 0);
            tick(); observe(nmi_n);
        end
        expect_val("t1_nmi_high", 1);
        tick(); observe(nmi_n);
        expect_val("t1_pending_clr", 0);
        snd_rd = 1; snd_addr = 0; tick(); idle();
        observe(pending);

        // strobes without cen are ignored
        cen = 0;
        expect_val("cen_pending", 0);
        expect_val("cen_latch2", 0);
        cmd_wr(2, 8'h77, 0);
        cen = 1;
        snd_addr = 2; #1;
        observe(pending); observe(snd_dout);

        // write and read of the same latch in one cycle
        cmd_wr(1, 8'h11, 0);
        snd_rd = 1; snd_addr = 1; tick(); idle();
        expect_val("t2_old", 8'h11);
        expect_val("t2_new", 8'h33);
        expect_val("t2_pending", 3'b010);
        expect_val("t2_nmi_off", 1);
        main_wr = 1; main_addr = 1; main_din = 8'h33;
        snd_rd = 1; snd_addr = 1; #1;
        observe(snd_dout);
        tick(); idle();
        observe(snd_dout); observe(pending); observe(nmi_n);

        // out-of-range address
        expect_val("oor_pending", 3'b010);
        expect_val("oor_dout", 8'hFF);
        cmd_wr(3, 8'hAB, 0);
        snd_addr = 3; #1;
        observe(pending); observe(snd_dout);

        // queued timer interrupts
        snd_int = 1; tick();
        expect_val("t3_int_first", 0); observe(int_n);
        snd_int = 0; tick();
        int_pulse(); int_pulse();
        iack = 1;
        expect_val("t3_ack1", 0); tick(); observe(int_n);
        expect_val("t3_ack2", 0); tick(); observe(int_n);
        expect_val("t3_ack3", 1); tick(); observe(int_n);
        iack = 0;

        // saturation at INT_QMAX and iack with empty queue
        for (int k = 0; k < 5; k++) int_pulse();
        iack = 1;
        expect_val("t4_ack1", 0); tick(); observe(int_n);
        expect_val("t4_ack2", 0); tick(); observe(int_n);
        expect_val("t4_ack3", 1); tick(); observe(int_n);
        expect_val("t4_ack4", 1); tick(); observe(int_n);
        iack = 0;
        snd_int = 1; tick();
        expect_val("t4_reedge", 0); observe(int_n);
        snd_int = 0; iack = 1; tick(); iack = 0;
        expect_val("t4_reack", 1); observe(int_n);

        // edge and iack together leave the count unchanged
        snd_int = 1; tick(); snd_int = 0; tick();
        snd_int = 1; iack = 1; tick();
        expect_val("both_hold", 0); observe(int_n);
        snd_int = 0; tick(); iack = 0;
        expect_val("both_drain", 1); observe(int_n);

        // reply latch
        snd_wr = 1; snd_din = 8'hC3; main_rd = 1; tick(); idle();
        expect_val("t5_dout", 8'hC3);   observe(main_dout);
        expect_val("t5_full", 1);       observe(reply_full);
        main_rd = 1; tick(); idle();
        expect_val("t5_cleared", 0);    observe(reply_full);
        expect_val("t5_dout_kept", 8'hC3); observe(main_dout);

`ifdef JTFRAME_SNDMBOX_FIFO_EN
        for (int k = 1; k <= 5; k++) cmd_wr(0, 8'(k), 0);
        expect_val("t6_ovf", 1);   observe(ovf_flag);
        expect_val("t6_pend", 1);  observe(pending[0]);
        snd_addr = 0;
        for (int k = 1; k <= 4; k++) begin
            expect_val("t6_pop", k);
            snd_rd = 1; #1; observe(snd_dout);
            tick(); idle();
        end
        expect_val("t6_pend_clr", 0); observe(pending[0]);
        expect_val("t6_pop_empty", 8'hFF);
        snd_rd = 1; #1; observe(snd_dout);
        tick(); idle();
        for (int k = 0; k < 4; k++) cmd_wr(0, 8'hA0 + 8'(k), 0);
        expect_val("t6_full_pp", 8'hA0);
        main_wr = 1; main_addr = 0; main_din = 8'hA4;
        snd_rd = 1; snd_addr = 0; #1; observe(snd_dout);
        tick(); idle();
        for (int k = 1; k <= 4; k++) begin
            expect_val("t6_drain", 8'hA0 + 8'(k));
            snd_rd = 1; #1; observe(snd_dout);
            tick(); idle();
        end
        expect_val("t6_drained", 0); observe(pending[0]);
        expect_val("t6_ovf_sticky", 1); observe(ovf_flag);
`else
        for (int k = 1; k <= 5; k++) cmd_wr(0, 8'(k), 0);
        snd_addr = 0; #1;
        expect_val("t6_latch0", 8'h05); observe(snd_dout);
        expect_val("t6_ovf_tied", 0);   observe(ovf_flag);
        expect_val("t6_pend", 1);       observe(pending[0]);
`endif

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
